input_conditioner: RTL and testbench

- Button front-end for the Galaga VGA game. It sits between the DE2-115 board keys (KEY[3:0], active-low, bouncy, asynchronous) and the game/vga core inputs.
- Per channel it synchronises the key to the system clock and debounces it.
- It outputs a clean active-high level plus one-cycle press and release pulses.
- Optional auto-repeat on press, intended for fire and movement keys.

---
 rtl/input_conditioner.sv | 145 ++++++++++++++
 tb/tb_input_conditioner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Key front-end: two-flop synchroniser, per-channel debounce, press/release pulses.
// Optional auto-repeat on press when INPUT_CONDITIONER_AUTOREPEAT_EN is defined.
module input_conditioner #(
    parameter int unsigned      N_BTN           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter int unsigned      REPEAT_DELAY    = 12500000,
    parameter int unsigned      REPEAT_PERIOD   = 2500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = {N_BTN{1'b1}}
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] key_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int unsigned   CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
        $bits(REPEAT_MASK) != N_BTN) begin : g_bad_params
        $error("input_conditioner: illegal parameter value");
    end

    logic [N_BTN-1:0] sync1_q, sync2_q, sync_q;
    logic [N_BTN-1:0] level_q, press_q, release_q;
    logic [N_BTN-1:0] rise, fall, press_d;
    logic [CW-1:0]    cnt_q [N_BTN];

    // Flops reset to 1 so a released key produces no spurious edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign sync_q = ~sync2_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic toggle;

        assign toggle  = (sync_q[i] != level_q[i]) && (cnt_q[i] == DB_MAX);
        assign rise[i] = toggle & ~level_q[i];
        assign fall[i] = toggle & level_q[i];

        always_ff @(posedge CLOCK_50 or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q[i]   <= '0;
                level_q[i] <= 1'b0;
            end else if (sync_q[i] == level_q[i]) begin
                cnt_q[i] <= '0;
            end else if (cnt_q[i] == DB_MAX) begin
                cnt_q[i]   <= '0;
                level_q[i] <= ~level_q[i];
            end else begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
            end
        end
    end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX);
    localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_REP  = 2'd2;

    logic [N_BTN-1:0] rpt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_rpt
        if (REPEAT_MASK[i]) begin : g_on
            logic [1:0]    state_q;
            logic [RW-1:0] rcnt_q;
            logic          fire;

            assign fire = ((state_q == ST_HOLD) && (rcnt_q == RD_MAX)) ||
                          ((state_q == ST_REP)  && (rcnt_q == RP_MAX));
            // A release on the expiry edge suppresses the repeat pulse.
            assign rpt[i] = fire & ~fall[i];

            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    state_q <= ST_IDLE;
                    rcnt_q  <= '0;
                end else if (fall[i]) begin
                    state_q <= ST_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            rcnt_q <= '0;
                            if (rise[i]) state_q <= ST_HOLD;
                        end
                        ST_HOLD: begin
                            if (fire) begin
                                state_q <= ST_REP;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RW'(1);
                            end
                        end
                        ST_REP: begin
                            if (fire) rcnt_q <= '0;
                            else      rcnt_q <= rcnt_q + RW'(1);
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_off
            assign rpt[i] = 1'b0;
        end
    end

    assign press_d = rise | rpt;
`else
    assign press_d = rise;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= fall;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: vector table plus hand-written repeat/reset sequences.
// Expectations follow INPUT_CONDITIONER_AUTOREPEAT_EN when it is defined.
module tb_input_conditioner;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_n;
    logic [3:0] btn_level, btn_press, btn_release;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] key;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vecs[$];

    input_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4),
        .REPEAT_MASK     (4'b1111)
    ) dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic add(input logic r, input logic [3:0] k, input logic [3:0] l,
                       input logic [3:0] p, input logic [3:0] q, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{rst: r, key: k, lvl: l, prs: p, rel: q});
    endtask

    task automatic step(input logic r, input logic [3:0] k);
        @(negedge clk);
        reset_n = r;
        key_n   = k;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    function automatic bit rep_press(input int r);
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        return (r == 0) || (r >= 8 && r <= 32 && (r % 4) == 0);
`else
        return r == 0;
`endif
    endfunction

    initial begin
        reset_n = 1'b1;
        key_n   = 4'hF;
        #2 reset_n = 1'b0;
        #1;
        check("reset level", -1, btn_level, 4'h0);
        check("reset press", -1, btn_press, 4'h0);
        check("reset release", -1, btn_release, 4'h0);

        // 1: idle keys
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 2);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 20);
        // 2: channel 0 press and release, 6-edge latency each way
        add(1, 4'hE, 4'h0, 4'h0, 4'h0, 5);
        add(1, 4'hE, 4'h1, 4'h1, 4'h0, 1);
        add(1, 4'hE, 4'h1, 4'h0, 4'h0, 1);
        add(1, 4'hF, 4'h1, 4'h0, 4'h0, 5);
        add(1, 4'hF, 4'h0, 4'h0, 4'h1, 1);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 3);
        // 3: bounce on channel 1 restarts the count
        add(1, 4'hD, 4'h0, 4'h0, 4'h0, 2);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 1);
        add(1, 4'hD, 4'h0, 4'h0, 4'h0, 5);
        add(1, 4'hD, 4'h2, 4'h2, 4'h0, 1);
        add(1, 4'hD, 4'h2, 4'h0, 4'h0, 1);
        add(1, 4'hF, 4'h2, 4'h0, 4'h0, 5);
        add(1, 4'hF, 4'h0, 4'h0, 4'h2, 1);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 2);
        // 4: simultaneous press, reset mid-debounce, fresh press after reset
        add(1, 4'h3, 4'h0, 4'h0, 4'h0, 5);
        add(1, 4'h3, 4'hC, 4'hC, 4'h0, 1);
        add(1, 4'h2, 4'hC, 4'h0, 4'h0, 2);
        add(0, 4'h2, 4'h0, 4'h0, 4'h0, 2);
        add(1, 4'h2, 4'h0, 4'h0, 4'h0, 5);
        add(1, 4'h2, 4'hD, 4'hD, 4'h0, 1);
        add(1, 4'h2, 4'hD, 4'h0, 4'h0, 1);
        add(1, 4'hF, 4'hD, 4'h0, 4'h0, 5);
        add(1, 4'hF, 4'h0, 4'h0, 4'hD, 1);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].key);
            check("tbl level", i, btn_level, vecs[i].lvl);
            check("tbl press", i, btn_press, vecs[i].prs);
            check("tbl release", i, btn_release, vecs[i].rel);
        end

        // 5/6: long hold on channel 0; release lands on a repeat expiry at r=36
        for (int r = -5; r <= 44; r++) begin
            step(1'b1, (r < 31) ? 4'hE : 4'hF);
            check("hold level", r, btn_level, (r >= 0 && r < 36) ? 4'h1 : 4'h0);
            check("hold press", r, btn_press, rep_press(r) ? 4'h1 : 4'h0);
            check("hold release", r, btn_release, (r == 36) ? 4'h1 : 4'h0);
        end

        // Asynchronous reset clears outputs without waiting for a clock edge
        for (int i = 0; i < 6; i++) step(1'b1, 4'hD);
        check("pre-reset level", 0, btn_level, 4'h2);
        check("pre-reset press", 0, btn_press, 4'h2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async reset level", 0, btn_level, 4'h0);
        check("async reset press", 0, btn_press, 4'h0);
        step(1'b0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'hF);
            check("post-reset level", i, btn_level, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
